huff_bigvalue_sequencer: RTL and testbench

//  Sequences the big_values Huffman decode of one MP3 granule/channel. Splits the pair range into

---
 rtl/mp3_huff_pkg.sv | 34 +++
 rtl/huff_bit_budget.sv | 35 +++
 rtl/huff_bigvalue_sequencer.sv | 144 ++++++++++++++
 tb/tb_huff_bigvalue_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_huff_pkg.sv
// Shared types and constants for the MP3 big_values Huffman sequencer.
package mp3_huff_pkg;

  localparam int MAX_CODE_BITS = 34;
  localparam int MAX_PAIRS     = 288;

  // Tables 4 and 14 do not exist in the standard; selecting one is a stream error.
  localparam logic [31:0] TABLE_UNUSED = 32'h0000_4010;

  localparam logic [3:0] LINBITS [32] = '{
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
    4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd10, 4'd13,
    4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd13
  };

  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_DECODE, S_ZERO_X, S_ZERO_Y,
    S_WRITE_X, S_WRITE_Y, S_DONE, S_ERROR
  } huff_seq_state_t;

  typedef struct packed {
    logic [8:0]      big_values;
    logic [8:0]      region1_start;
    logic [8:0]      region2_start;
    logic [2:0][4:0] table_sel;
  } huff_cfg_t;

  function automatic logic [1:0] region_of(input logic [8:0] idx, input logic [8:0] r1,
                                           input logic [8:0] r2);
    return (idx < r1) ? 2'd0 : (idx < r2) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/huff_bit_budget.sv
// Granule bit counter and per-pair code-length counter with budget/timeout flags.
module huff_bit_budget #(
  parameter int BITCNT_W      = 12,
  parameter int MAX_CODE_BITS = 34
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_all,
  input  logic                clr_code,
  input  logic                inc,
  input  logic [BITCNT_W-1:0] bit_budget,
  output logic [BITCNT_W-1:0] bits_used,
  output logic                timeout,
  output logic                budget_hit
);
  localparam int CB_W = $clog2(MAX_CODE_BITS + 1);

  logic [CB_W-1:0] code_bits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bits_used <= '0;
      code_bits <= '0;
    end else begin
      if (clr_all)  bits_used <= '0;
      else if (inc) bits_used <= bits_used + 1'b1;
      if (clr_code) code_bits <= '0;
      else if (inc) code_bits <= code_bits + 1'b1;
    end
  end

  assign timeout    = (code_bits == CB_W'(MAX_CODE_BITS));
  assign budget_hit = (bits_used >= bit_budget);

endmodule

// File: rtl/huff_bigvalue_sequencer.sv
// Walks the big_values pairs of one granule: picks the region table, meters bits into the
// external decoder bank and writes each decoded (x,y) pair to the sample buffer.
module huff_bigvalue_sequencer #(
  parameter int SAMPLE_W      = 16,
  parameter int ADDR_W        = 10,
  parameter int BITCNT_W      = 12,
  parameter int MAX_CODE_BITS = mp3_huff_pkg::MAX_CODE_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8:0]          big_values,
  input  logic [8:0]          region1_start,
  input  logic [8:0]          region2_start,
  input  logic [2:0][4:0]     table_sel,
  input  logic [BITCNT_W-1:0] bit_budget,
  input  logic                axiiv,
  input  logic                axiid,
  output logic                in_ready,
  output logic [4:0]          dec_sel,
  output logic                dec_rst,
  output logic                dec_bit_valid,
  output logic                dec_bit,
  input  logic                dec_valid,
  input  logic [SAMPLE_W-1:0] dec_x,
  input  logic [SAMPLE_W-1:0] dec_y,
  output logic                smp_we,
  output logic [ADDR_W-1:0]   smp_addr,
  output logic [SAMPLE_W-1:0] smp_data,
  output logic [BITCNT_W-1:0] bits_used,
  output logic                done,
  output logic                err
);
  import mp3_huff_pkg::*;

  huff_seq_state_t     state, state_n;
  huff_cfg_t           cfg;
  logic [BITCNT_W-1:0] budget_q;
  logic [8:0]          pair_idx;
  logic [9:0]          next_idx;
  logic [SAMPLE_W-1:0] x_q, y_q;
  logic [4:0]          cur_tbl;
  logic                last_pair, region_chg, timeout, budget_hit;

  assign next_idx   = {1'b0, pair_idx} + 10'd1;
  assign last_pair  = (next_idx == {1'b0, cfg.big_values});
  assign region_chg = region_of(next_idx[8:0], cfg.region1_start, cfg.region2_start) !=
                      region_of(pair_idx, cfg.region1_start, cfg.region2_start);
  assign cur_tbl    = cfg.table_sel[region_of(pair_idx, cfg.region1_start, cfg.region2_start)];

  assign dec_bit_valid = axiiv & in_ready;
  assign dec_bit       = axiid;

  huff_bit_budget #(.BITCNT_W(BITCNT_W), .MAX_CODE_BITS(MAX_CODE_BITS)) u_budget (
    .clk        (clk),
    .rst        (rst),
    .clr_all    (state == S_IDLE && start),
    .clr_code   (state != S_DECODE),
    .inc        (dec_bit_valid),
    .bit_budget (budget_q),
    .bits_used  (bits_used),
    .timeout    (timeout),
    .budget_hit (budget_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cfg      <= '0;
      budget_q <= '0;
      pair_idx <= '0;
      dec_sel  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && start) begin
        cfg      <= '{big_values, region1_start, region2_start, table_sel};
        budget_q <= bit_budget;
        pair_idx <= '0;
      end
      if (state == S_WRITE_Y || state == S_ZERO_Y) pair_idx <= next_idx[8:0];
      if (state == S_SELECT) dec_sel <= cur_tbl;
      if (state == S_DECODE && dec_valid) begin
        x_q <= dec_x;
        y_q <= dec_y;
      end
      if (state == S_IDLE && start) err <= 1'b0;
      else if (state_n == S_ERROR)  err <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    dec_rst  = 1'b0;
    smp_we   = 1'b0;
    smp_addr = '0;
    smp_data = '0;
    done     = 1'b0;
    case (state)
      S_IDLE:
        if (start) state_n = (big_values == 9'd0) ? S_DONE : S_SELECT;
      S_SELECT: begin
        dec_rst = 1'b1;
        if (TABLE_UNUSED[cur_tbl]) state_n = S_ERROR;
        else if (cur_tbl == 5'd0)  state_n = S_ZERO_X;
        else                       state_n = S_DECODE;
      end
      S_DECODE: begin
        // The cycle dec_valid is seen is a bubble, so no bit reaches a stale table.
        in_ready = !dec_valid && !timeout && !budget_hit;
        if (dec_valid)                  state_n = S_WRITE_X;
        else if (timeout || budget_hit) state_n = S_ERROR;
      end
      S_WRITE_X, S_ZERO_X: begin
        smp_we   = 1'b1;
        smp_addr = ADDR_W'({pair_idx, 1'b0});
        smp_data = (state == S_WRITE_X) ? x_q : '0;
        state_n  = (state == S_WRITE_X) ? S_WRITE_Y : S_ZERO_Y;
      end
      S_WRITE_Y, S_ZERO_Y: begin
        smp_we   = 1'b1;
        smp_addr = ADDR_W'({pair_idx, 1'b1});
        smp_data = (state == S_WRITE_Y) ? y_q : '0;
        if (last_pair)              state_n = S_DONE;
        else if (region_chg)        state_n = S_SELECT;
        else if (state == S_ZERO_Y) state_n = S_ZERO_X;
        else begin
          state_n = S_DECODE;
          dec_rst = 1'b1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      S_ERROR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_huff_bigvalue_sequencer.sv
// Bench for huff_bigvalue_sequencer: toy prefix-code decoder bank, table vectors and random
// granules checked against a pair-level reference model.
module tb_huff_bigvalue_sequencer;
  localparam int SW = 16;
  localparam int AW = 10;
  localparam int BW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start, axiiv, axiid, in_ready, dec_rst, dec_bit_valid, dec_bit, dec_valid;
  logic smp_we, done, err;
  logic [8:0] big_values, region1_start, region2_start;
  logic [2:0][4:0] table_sel;
  logic [BW-1:0] bit_budget, bits_used;
  logic [4:0] dec_sel;
  logic [SW-1:0] dec_x, dec_y, smp_data;
  logic [AW-1:0] smp_addr;

  huff_bigvalue_sequencer #(.SAMPLE_W(SW), .ADDR_W(AW), .BITCNT_W(BW), .MAX_CODE_BITS(34)) dut (
    .clk(clk), .rst(rst), .start(start), .big_values(big_values),
    .region1_start(region1_start), .region2_start(region2_start), .table_sel(table_sel),
    .bit_budget(bit_budget), .axiiv(axiiv), .axiid(axiid), .in_ready(in_ready),
    .dec_sel(dec_sel), .dec_rst(dec_rst), .dec_bit_valid(dec_bit_valid), .dec_bit(dec_bit),
    .dec_valid(dec_valid), .dec_x(dec_x), .dec_y(dec_y), .smp_we(smp_we),
    .smp_addr(smp_addr), .smp_data(smp_data), .bits_used(bits_used), .done(done), .err(err)
  );

  int ntests = 0;
  int nfail  = 0;

  function automatic void chk(string nm, int act, int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  // Toy decoder: 11->(0,0); 10 s->(0,+-1); 01 s->(+-1,0); 00 nnnn sx sy->(+-(n+tbl),+-(n+1)).
  // nnnn=1111 never terminates, which exercises the per-pair timeout.
  logic [7:0] cb  = '0;
  int         clen = 0;
  int         dn, dt;
  always @(posedge clk) begin
    if (dec_rst) begin
      cb   <= '0;
      clen <= 0;
    end else if (dec_bit_valid) begin
      if (clen < 8) cb[7-clen] <= dec_bit;
      clen <= clen + 1;
    end
  end
  always @* begin
    dec_valid = 1'b0;
    dec_x     = '0;
    dec_y     = '0;
    dt        = int'(dec_sel);
    dn        = int'(cb[5:2]);
    case (cb[7:6])
      2'b11: dec_valid = (clen == 2);
      2'b10: begin dec_valid = (clen == 3); dec_y = cb[5] ? -16'sd1 : 16'sd1; end
      2'b01: begin dec_valid = (clen == 3); dec_x = cb[5] ? -16'sd1 : 16'sd1; end
      default: if (dn != 15 && clen == 8) begin
        dec_valid = 1'b1;
        dec_x = 16'(cb[1] ? -(dn + dt) : (dn + dt));
        dec_y = 16'(cb[0] ? -(dn + 1) : (dn + 1));
      end
    endcase
  end

  // Bit source, optionally valid only every other cycle.
  logic sbits [4096];
  int   slen = 0;
  int   ptr  = 0;
  bit   gap  = 0;
  bit   ph   = 0;
  initial begin
    bit acc;
    axiiv = 1'b0;
    axiid = 1'b0;
    forever begin
      @(negedge clk);
      acc = axiiv && in_ready;
      @(posedge clk);
      #1;
      if (acc) ptr++;
      ph    = !ph;
      axiiv = (ptr < slen) && (!gap || ph);
      axiid = (ptr < slen) ? sbits[ptr] : 1'b0;
    end
  end

  typedef struct { int a; int d; } wr_t;
  wr_t wq[$];
  wr_t mq[$];

  // Pair-level reference: codeword length from the prefix, then budget/timeout arithmetic.
  task automatic model(input int bv, r1, r2, t0, t1, t2, budget, output bit merr, output int mbits);
    int ts[3];
    int pos;
    ts = '{t0, t1, t2};
    pos = 0;
    merr = 0;
    mq.delete();
    for (int p = 0; p < bv && !merr; p++) begin
      int r, t, len, x, y, n;
      bit inf;
      r = (p < r1) ? 0 : (p < r2) ? 1 : 2;
      t = ts[r];
      if (t == 4 || t == 14) merr = 1;
      else if (t == 0) begin
        mq.push_back('{2*p, 0});
        mq.push_back('{2*p+1, 0});
      end else begin
        inf = 0; x = 0; y = 0; len = 0;
        case ({sbits[pos], sbits[pos+1]})
          2'b11: len = 2;
          2'b10: begin len = 3; y = sbits[pos+2] ? -1 : 1; end
          2'b01: begin len = 3; x = sbits[pos+2] ? -1 : 1; end
          default: begin
            n = {sbits[pos+2], sbits[pos+3], sbits[pos+4], sbits[pos+5]};
            if (n == 15) inf = 1;
            else begin
              len = 8;
              x = sbits[pos+6] ? -(n + t) : (n + t);
              y = sbits[pos+7] ? -(n + 1) : (n + 1);
            end
          end
        endcase
        if (inf) begin
          pos += ((budget - pos) < 34) ? (budget - pos) : 34;
          merr = 1;
        end else if ((budget - pos) < len) begin
          pos = budget;
          merr = 1;
        end else begin
          pos += len;
          mq.push_back('{2*p, x});
          mq.push_back('{2*p+1, y});
        end
      end
    end
    mbits = pos;
  endtask

  task automatic run_case(input string nm, input int bv, r1, r2, t0, t1, t2, budget,
                          input bit g, input bit pk, output bit o_err, output int o_bits);
    bit seen_done, fwd_bad;
    @(negedge clk);
    gap = g; ptr = 0; wq.delete();
    big_values    = 9'(bv);
    region1_start = 9'(r1);
    region2_start = 9'(r2);
    table_sel     = {5'(t2), 5'(t1), 5'(t0)};
    bit_budget    = BW'(budget);
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_done = 0; o_err = 0; fwd_bad = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (dec_bit_valid !== (axiiv & in_ready)) fwd_bad = 1;
      if (dec_bit_valid && dec_bit !== axiid) fwd_bad = 1;
      if (dec_rst && dec_bit_valid) fwd_bad = 1;
      if (smp_we) wq.push_back('{int'(smp_addr), int'($signed(smp_data))});
      if (done) begin seen_done = 1; break; end
      if (err)  begin o_err = 1; break; end
      // A start while busy must be ignored.
      if (pk && cyc == 4) begin start = 1'b1; big_values = 9'd0; end
      if (pk && cyc == 5) start = 1'b0;
      @(negedge clk);
    end
    o_bits = int'(bits_used);
    start = 1'b0;
    if (!seen_done && !o_err) chk({nm, ".finished"}, 0, 1);
    chk({nm, ".fwd_ok"}, int'(fwd_bad), 0);
    chk({nm, ".done_xor_err"}, int'(seen_done), int'(!o_err));
    @(negedge clk);
    chk({nm, ".done_1cyc"}, int'(done), 0);
    chk({nm, ".bits_held"}, int'(bits_used), o_bits);
    @(negedge clk);
  endtask

  task automatic check_reset();
    chk("rst.in_ready", int'(in_ready), 0);
    chk("rst.dec_rst", int'(dec_rst), 0);
    chk("rst.dec_bit_valid", int'(dec_bit_valid), 0);
    chk("rst.smp_we", int'(smp_we), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.dec_sel", int'(dec_sel), 0);
    chk("rst.smp_addr", int'(smp_addr), 0);
    chk("rst.smp_data", int'(smp_data), 0);
    chk("rst.bits_used", int'(bits_used), 0);
  endtask

  typedef struct {
    int bv, r1, r2, t0, t1, t2, budget;
    logic [63:0] s;
    int n;
    bit g, pk;
    bit xerr;
    int xbits, xnwr;
    int xd[6];
  } vec_t;
  vec_t vt[10];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    e, merr;
    int    b, mbits, lim;
    string nm;
    vt[0] = '{2, 2, 2, 3, 3, 3, 100, {5'b11101, 59'b0}, 5, 0, 0, 0, 5, 4, '{0, 0, 0, -1, 0, 0}};
    vt[1] = '{3, 1, 3, 3, 0, 0, 100, {3'b010, 61'b0}, 3, 0, 0, 0, 3, 6, '{1, 0, 0, 0, 0, 0}};
    vt[2] = '{2, 1, 2, 3, 7, 9, 100, {10'b1100000000, 54'b0}, 10, 0, 0, 0, 10, 4, '{0, 0, 7, 1, 0, 0}};
    vt[3] = '{2, 2, 2, 4, 3, 3, 100, {5'b11101, 59'b0}, 5, 0, 0, 1, 0, 0, '{0, 0, 0, 0, 0, 0}};
    vt[4] = '{1, 1, 1, 5, 5, 5, 3, {8'b00000000, 56'b0}, 8, 0, 0, 1, 3, 0, '{0, 0, 0, 0, 0, 0}};
    vt[5] = '{1, 1, 1, 5, 5, 5, 8, {8'b00001001, 56'b0}, 8, 0, 0, 0, 8, 2, '{7, -3, 0, 0, 0, 0}};
    vt[6] = '{1, 1, 1, 2, 2, 2, 200, {6'b001111, 58'b0}, 40, 0, 0, 1, 34, 0, '{0, 0, 0, 0, 0, 0}};
    vt[7] = '{0, 0, 0, 3, 3, 3, 100, 64'b0, 0, 0, 0, 0, 0, 0, '{0, 0, 0, 0, 0, 0}};
    vt[8] = '{2, 5, 9, 0, 14, 4, 100, 64'b0, 0, 0, 0, 0, 0, 4, '{0, 0, 0, 0, 0, 0}};
    vt[9] = '{2, 2, 2, 3, 3, 3, 100, {5'b11101, 59'b0}, 5, 1, 1, 0, 5, 4, '{0, 0, 0, -1, 0, 0}};

    rst = 1'b1; start = 1'b0; big_values = '0; region1_start = '0; region2_start = '0;
    table_sel = '0; bit_budget = '0;
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;

    foreach (vt[k]) begin
      nm = $sformatf("v%0d", k);
      for (int i = 0; i < 4096; i++) sbits[i] = (i < 64) ? vt[k].s[63-i] : 1'b0;
      slen = vt[k].n;
      run_case(nm, vt[k].bv, vt[k].r1, vt[k].r2, vt[k].t0, vt[k].t1, vt[k].t2, vt[k].budget,
               vt[k].g, vt[k].pk, e, b);
      chk({nm, ".err"}, int'(e), int'(vt[k].xerr));
      chk({nm, ".bits"}, b, vt[k].xbits);
      chk({nm, ".nwr"}, wq.size(), vt[k].xnwr);
      lim = (wq.size() < 6) ? wq.size() : 6;
      for (int i = 0; i < lim; i++) begin
        chk($sformatf("%s.addr%0d", nm, i), wq[i].a, i);
        chk($sformatf("%s.data%0d", nm, i), wq[i].d, vt[k].xd[i]);
      end
    end

    // Abort mid-granule, then make sure the next granule is clean.
    for (int i = 0; i < 4096; i++) sbits[i] = 1'($urandom);
    slen = 4096;
    @(negedge clk);
    gap = 0; ptr = 0;
    big_values = 9'd10; region1_start = 9'd10; region2_start = 9'd10;
    table_sel = {5'd6, 5'd6, 5'd6}; bit_budget = BW'(1000); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset();
    rst = 1'b0;

    for (int it = 0; it < 40; it++) begin
      int bv, r1, r2, t[3], bud;
      bit g;
      for (int i = 0; i < 4096; i++) sbits[i] = 1'($urandom);
      slen = 4096;
      bv = $urandom_range(0, 14);
      r1 = $urandom_range(0, bv + 1);
      r2 = $urandom_range(r1, bv + 2);
      for (int r = 0; r < 3; r++) t[r] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
      bud = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : 1000;
      g = 1'($urandom);
      nm = $sformatf("r%0d", it);
      model(bv, r1, r2, t[0], t[1], t[2], bud, merr, mbits);
      run_case(nm, bv, r1, r2, t[0], t[1], t[2], bud, g, 0, e, b);
      chk({nm, ".err"}, int'(e), int'(merr));
      chk({nm, ".bits"}, b, mbits);
      chk({nm, ".nwr"}, wq.size(), mq.size());
      lim = (wq.size() < mq.size()) ? wq.size() : mq.size();
      for (int i = 0; i < lim; i++) begin
        chk($sformatf("%s.addr%0d", nm, i), wq[i].a, mq[i].a);
        chk($sformatf("%s.data%0d", nm, i), wq[i].d, mq[i].d);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
